// File: rtl/pic_priority_scheduler.sv
// pic_priority_scheduler
// Interrupt scheduler for an 8259-style PIC. Tracks pending (irr) and in-service
// (isr) levels, picks the highest-priority unmasked request under fully-nested
// or rotating priority, and sequences the inta1/inta2 acknowledge handshake.
//
// Optional feature macro: PIC_ROTATE_EN builds the rotating-priority pointer.
// Without it, `rotate` is ignored and IR0 is always highest.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ir_in           request lines (already synchronised)
//   level_mode      1 = level-triggered, 0 = edge-triggered
//   imr             interrupt mask (1 = masked)
//   rotate, aeoi    rotating priority / automatic EOI controls
//   eoi, seoi       non-specific / specific EOI strobes, seoi_level target
//   inta1, inta2    acknowledge pulses
//   int_req         request to CPU
//   vector_num      level being serviced
//   vector_valid    one-cycle pulse after inta2
//   irr, isr        request / in-service registers
module pic_priority_scheduler #(
    parameter int unsigned NUM_IR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] ir_in,
    input  logic              level_mode,
    input  logic [NUM_IR-1:0] imr,
    input  logic              rotate,
    input  logic              aeoi,
    input  logic              eoi,
    input  logic              seoi,
    input  logic [2:0]        seoi_level,
    input  logic              inta1,
    input  logic              inta2,
    output logic              int_req,
    output logic [2:0]        vector_num,
    output logic              vector_valid,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK1} state_t;

    state_t            state, state_nx;
    logic [NUM_IR-1:0] prev_ir;
    logic [NUM_IR-1:0] irr_nx, isr_nx;
    logic [2:0]        vector_num_nx;
    logic              vector_valid_nx, int_req_nx;
    logic              spurious, spurious_nx;
    logic [2:0]        lowest;

    // Rank of the highest-priority set bit (0 = highest, 8 = none).
    function automatic logic [3:0] top_rank(input logic [NUM_IR-1:0] vec,
                                            input logic [2:0] low);
        logic [3:0] r;
        r = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (vec[3'(low + 3'(k) + 3'd1)]) r = 4'(k);
        end
        return r;
    endfunction

    logic [3:0] cand_rank, isr_rank;
    logic [2:0] cand_level, isr_level;
    logic       eligible;

    assign cand_rank  = top_rank(irr & ~imr, lowest);
    assign isr_rank   = top_rank(isr, lowest);
    assign cand_level = 3'(lowest + cand_rank[2:0] + 3'd1);
    assign isr_level  = 3'(lowest + isr_rank[2:0] + 3'd1);
    // Candidate must strictly out-rank everything in service (rank 8 = none).
    assign eligible   = (cand_rank < isr_rank);

`ifdef PIC_ROTATE_EN
    logic [2:0] lowest_nx;
`else
    logic unused_rotate;
    assign unused_rotate = rotate;
    assign lowest        = 3'd7;
`endif

    // Next-state and register-input logic.
    always_comb begin
        logic [NUM_IR-1:0] isr_clr, isr_set, irr_clr;
        state_nx        = state;
        vector_num_nx   = vector_num;
        vector_valid_nx = 1'b0;
        spurious_nx     = spurious;
        isr_clr         = '0;
        isr_set         = '0;
        irr_clr         = '0;
`ifdef PIC_ROTATE_EN
        lowest_nx       = lowest;
`endif

        case (state)
            ST_IDLE: begin
                if (eligible) state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (inta1) begin
                    state_nx = ST_ACK1;
                    if (eligible) begin
                        vector_num_nx = cand_level;
                        isr_set       = NUM_IR'(1) << cand_level;
                        irr_clr       = level_mode ? '0 : (NUM_IR'(1) << cand_level);
                        spurious_nx   = 1'b0;
                    end else begin
                        vector_num_nx = 3'd7;
                        spurious_nx   = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta2) begin
                    state_nx        = ST_IDLE;
                    vector_valid_nx = 1'b1;
                    if (aeoi && !spurious) begin
                        isr_clr = NUM_IR'(1) << vector_num;
`ifdef PIC_ROTATE_EN
                        if (rotate) lowest_nx = vector_num;
`endif
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // EOI works on the pre-cycle isr; an explicit EOI overrides AEOI rotation.
        if (seoi) begin
            isr_clr = isr_clr | (NUM_IR'(1) << seoi_level);
`ifdef PIC_ROTATE_EN
            if (rotate) lowest_nx = seoi_level;
`endif
        end else if (eoi && !isr_rank[3]) begin
            isr_clr = isr_clr | (NUM_IR'(1) << isr_level);
`ifdef PIC_ROTATE_EN
            if (rotate) lowest_nx = isr_level;
`endif
        end

        isr_nx     = (isr & ~isr_clr) | isr_set;
        irr_nx     = level_mode ? ir_in : ((irr & ~irr_clr) | (ir_in & ~prev_ir));
        int_req_nx = (state_nx != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            prev_ir      <= '0;
            irr          <= '0;
            isr          <= '0;
            vector_num   <= 3'd0;
            vector_valid <= 1'b0;
            int_req      <= 1'b0;
            spurious     <= 1'b0;
        end else begin
            state        <= state_nx;
            prev_ir      <= ir_in;
            irr          <= irr_nx;
            isr          <= isr_nx;
            vector_num   <= vector_num_nx;
            vector_valid <= vector_valid_nx;
            int_req      <= int_req_nx;
            spurious     <= spurious_nx;
        end
    end

`ifdef PIC_ROTATE_EN
    // Rotation pointer: lowest-priority level.
    always_ff @(posedge clk) begin
        if (rst) lowest <= 3'd7;
        else     lowest <= lowest_nx;
    end
`endif

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Self-checking bench for pic_priority_scheduler: directed scenarios plus
// randomized traffic, every cycle compared against a priority-rank model.
module tb_pic_priority_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir_in = '0;
    logic       level_mode = 1'b0;
    logic [7:0] imr = '0;
    logic       rotate = 1'b0, aeoi = 1'b0, eoi = 1'b0, seoi = 1'b0;
    logic [2:0] seoi_level = '0;
    logic       inta1 = 1'b0, inta2 = 1'b0;
    logic       int_req, vector_valid;
    logic [2:0] vector_num;
    logic [7:0] irr, isr;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIC_ROTATE_EN
    localparam bit ROT_BUILT = 1'b1;
`else
    localparam bit ROT_BUILT = 1'b0;
`endif

    pic_priority_scheduler #(.NUM_IR(8)) dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .level_mode(level_mode), .imr(imr),
        .rotate(rotate), .aeoi(aeoi), .eoi(eoi), .seoi(seoi), .seoi_level(seoi_level),
        .inta1(inta1), .inta2(inta2), .int_req(int_req), .vector_num(vector_num),
        .vector_valid(vector_valid), .irr(irr), .isr(isr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = requesting, 2 = first ack taken.
    logic [7:0] m_irr, m_isr, m_prev;
    int         m_phase, m_vec, m_low;
    bit         m_vv, m_intreq, m_spur;

    function automatic int rank(input int lvl);
        return (lvl - m_low + 15) % 8;
    endfunction

    function automatic int best(input logic [7:0] v);
        int b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank(i) < rank(b))) b = i;
        return b;
    endfunction

    task automatic model_update();
        int cand, top, nphase, nvec, nlow, setbit;
        bit elig, rot, nspur, nvv;
        logic [7:0] nisr, clr;
        if (rst) begin
            m_irr = 0; m_isr = 0; m_prev = 0; m_phase = 0; m_vec = 0;
            m_low = 7; m_vv = 0; m_intreq = 0; m_spur = 0;
        end else begin
            cand = best(m_irr & ~imr);
            top  = best(m_isr);
            elig = (cand >= 0) && (top < 0 || rank(cand) < rank(top));
            rot  = ROT_BUILT && rotate;
            nphase = m_phase; nvec = m_vec; nlow = m_low; nspur = m_spur;
            nvv = 0; nisr = m_isr; clr = 0; setbit = -1;
            if (m_phase == 0) begin
                if (elig) nphase = 1;
            end else if (m_phase == 1) begin
                if (inta1) begin
                    nphase = 2;
                    if (elig) begin
                        nvec = cand; setbit = cand; nspur = 0;
                        if (!level_mode) clr[cand] = 1'b1;
                    end else begin
                        nvec = 7; nspur = 1;
                    end
                end
            end else if (inta2) begin
                nphase = 0; nvv = 1;
                if (aeoi && !m_spur) begin
                    nisr[m_vec] = 1'b0;
                    if (rot) nlow = m_vec;
                end
            end
            if (seoi) begin
                nisr[seoi_level] = 1'b0;
                if (rot) nlow = int'(seoi_level);
            end else if (eoi && top >= 0) begin
                nisr[top] = 1'b0;
                if (rot) nlow = top;
            end
            if (setbit >= 0) nisr[setbit] = 1'b1;
            m_irr   = level_mode ? ir_in : ((m_irr & ~clr) | (ir_in & ~m_prev));
            m_prev  = ir_in;
            m_isr   = nisr;
            m_phase = nphase; m_vec = nvec; m_low = nlow; m_spur = nspur;
            m_vv    = nvv;
            m_intreq = (nphase != 0);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("int_req", 32'(int_req), 32'(m_intreq));
        check("vector_num", 32'(vector_num), 32'(m_vec));
        check("vector_valid", 32'(vector_valid), 32'(m_vv));
        check("irr", 32'(irr), 32'(m_irr));
        check("isr", 32'(isr), 32'(m_isr));
        inta1 = 0; inta2 = 0; eoi = 0; seoi = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_isr", 32'(isr), 32'h0);
        check("rst_vnum", 32'(vector_num), 32'h0);

        // Edge request and EOI
        ir_in = 8'h08; step();
        check("edge_irr", 32'(irr), 32'h08);
        step();
        check("edge_intreq", 32'(int_req), 32'h1);
        inta1 = 1; step();
        check("edge_isr", 32'(isr), 32'h08);
        check("edge_irr_clr", 32'(irr), 32'h00);
        check("edge_vnum", 32'(vector_num), 32'h3);
        inta2 = 1; step();
        check("edge_vvalid", 32'(vector_valid), 32'h1);
        eoi = 1; step();
        check("edge_eoi", 32'(isr), 32'h00);

        // Nesting
        ir_in = 8'h00; step();
        ir_in = 8'h04; step(); step();
        inta1 = 1; step(); inta2 = 1; step();
        check("nest_isr", 32'(isr), 32'h04);
        ir_in = 8'h24; step(); step(); step();
        check("nest_blocked", 32'(int_req), 32'h0);
        ir_in = 8'h26; step(); step();
        check("nest_intreq", 32'(int_req), 32'h1);
        inta1 = 1; step();
        check("nest_vnum", 32'(vector_num), 32'h1);
        inta2 = 1; step();
        eoi = 1; step(); eoi = 1; step();

        // Masking
        do_reset();
        ir_in = 8'h00; imr = 8'h02; step();
        ir_in = 8'h02; step(); step();
        check("mask_irr", 32'(irr), 32'h02);
        check("mask_intreq", 32'(int_req), 32'h0);
        imr = 8'h00; step(); step();
        check("unmask_intreq", 32'(int_req), 32'h1);

        // Spurious
        do_reset();
        level_mode = 1; ir_in = 8'h10; step(); step();
        check("spur_intreq", 32'(int_req), 32'h1);
        ir_in = 8'h00; step();
        inta1 = 1; step();
        check("spur_vnum", 32'(vector_num), 32'h7);
        check("spur_isr", 32'(isr), 32'h0);
        inta2 = 1; step();

`ifdef PIC_ROTATE_EN
        // Rotation with AEOI
        do_reset();
        level_mode = 0; rotate = 1; aeoi = 1; ir_in = 8'h04; step(); step();
        inta1 = 1; step(); inta2 = 1; step();
        check("rot_isr", 32'(isr), 32'h0);
        ir_in = 8'h16; step(); step();
        inta1 = 1; step();
        check("rot_vnum", 32'(vector_num), 32'h4);
        inta2 = 1; step();
        rotate = 0; aeoi = 0;
`endif

        // Reset mid-handshake
        do_reset();
        level_mode = 0; ir_in = 8'h01; step(); step();
        inta1 = 1; step();
        rst = 1; step(); rst = 0;
        check("midrst_intreq", 32'(int_req), 32'h0);
        check("midrst_isr", 32'(isr), 32'h0);
        check("midrst_vnum", 32'(vector_num), 32'h0);
        inta2 = 1; step();
        check("midrst_vvalid", 32'(vector_valid), 32'h0);

        // Randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            level_mode = 1'($urandom_range(0, 1));
            aeoi       = 1'($urandom_range(0, 1));
            rotate     = 1'($urandom_range(0, 1));
            ir_in      = '0;
            imr        = '0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 3) == 0) ir_in = ir_in ^ 8'(1 << $urandom_range(0, 7));
                if ($urandom_range(0, 39) == 0) imr = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
                inta1      = ($urandom_range(0, 3) == 0);
                inta2      = ($urandom_range(0, 3) == 0);
                eoi        = ($urandom_range(0, 7) == 0);
                seoi       = ($urandom_range(0, 15) == 0);
                seoi_level = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 199) == 0) rst = 1;
                step();
                rst = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_priority_scheduler.md
# pic_priority_scheduler

Synchronous interrupt scheduler for the 8259-style PIC: tracks pending requests (IRR) and in-service levels (ISR), resolves the highest-priority unmasked request under fully-nested or rotating priority, and sequences the two-pulse acknowledge handshake. It sits between the raw IR pins and the PIC control unit. The control unit supplies the mode, mask and EOI commands, and consumes `int_req` and `vector_num`.

## Interface
Parameters:
- `NUM_IR`, 8: number of request lines. Fixed at 8; the 3-bit level encoding depends on it.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ir_in`  in  8  raw interrupt request lines, already synchronised to `clk`.
- `level_mode`  in  1  1 = level-triggered, 0 = edge-triggered.
- `imr`  in  8  interrupt mask; 1 masks that level.
- `rotate`  in  1  1 = rotating priority, 0 = fully nested with IR0 highest.
- `aeoi`  in  1  automatic EOI at the end of the second acknowledge.
- `eoi`  in  1  one-cycle strobe: non-specific EOI.
- `seoi`  in  1  one-cycle strobe: specific EOI for `seoi_level`.
- `seoi_level`  in  3  level cleared by `seoi`.
- `inta1`  in  1  one-cycle strobe: first acknowledge pulse.
- `inta2`  in  1  one-cycle strobe: second acknowledge pulse.
- `int_req`  out  1  interrupt request to the CPU.
- `vector_num`  out  3  level being serviced; valid from the cycle after `inta1`.
- `vector_valid`  out  1  one-cycle pulse the cycle after `inta2`.
- `irr`  out  8  interrupt request register.
- `isr`  out  8  in-service register.

## Operation
- **IRR, edge mode:** the previous `ir_in` is registered. `irr[i]` sets on a 0→1 edge of `ir_in[i]`. It clears when that level is latched at `inta1`.
- **IRR, level mode:** `irr` equals the registered `ir_in`, every cycle.
- **Priority:** a 3-bit `lowest` pointer marks the lowest-priority level, so `lowest+1` (mod 8) is highest. The pointer is 7 on reset and stays 7 in fixed mode.
- **Candidate and nesting:** the candidate is the highest-priority set bit of `irr & ~imr`. It is eligible only if its priority is strictly higher than the highest set `isr` bit (fully-nested blocking).
- **States:** `IDLE`, `REQ`, `ACK1`.
  - `IDLE` → `REQ` when an eligible candidate exists. `int_req` goes to 1.
  - `REQ` + `inta1` → `ACK1`.
    - If a candidate is still eligible: latch it into `vector_num`, set `isr[vector_num]`, and clear the IRR bit in edge mode.
    - If none is eligible (request withdrawn): `vector_num` = 7 and ISR is unchanged (spurious IR7).
  - `ACK1` + `inta2` → `IDLE`. `int_req` goes to 0 and `vector_valid` pulses.
    - If `aeoi` is set and the acknowledge was not spurious, clear `isr[vector_num]`.
    - If `rotate` is also set, `lowest` becomes `vector_num`.
  - `inta2` in `IDLE`/`REQ` and `inta1` in `IDLE`/`ACK1` are ignored.
- **EOI:**
  - `eoi` clears the highest-priority set `isr` bit; with `rotate` set, `lowest` becomes that level. With `isr` = 0 it has no effect.
  - `seoi` clears `isr[seoi_level]`; with `rotate` set, `lowest` becomes `seoi_level`.
  - `eoi` and `seoi` in the same cycle: `seoi` wins.
- **Same-cycle EOI and `inta1`:** the EOI is evaluated on the pre-cycle ISR. The new ISR bit is set afterwards, so the two never cancel.
- **Masking:** changing `imr` while in `REQ` leaves `int_req` high. The decision is re-evaluated at `inta1`.

## Timing
- **Reset values:** `int_req`=0, `vector_num`=0, `vector_valid`=0, `irr`=0, `isr`=0. The previous-`ir_in` register is 0, state is `IDLE`, `lowest` = 7.
- **Reset mid-handshake:** returns to `IDLE` in one cycle and discards the acknowledge.
- **Request latency:** an `ir_in` edge at cycle N appears in `irr` at N+1 and raises `int_req` at N+2.
- `vector_num` and `isr` update at `inta1`+1. `vector_valid` and AEOI clearing happen at `inta2`+1.
- **Back-to-back service:** the next request can raise `int_req` no earlier than 1 cycle after return to `IDLE`.
- All outputs are registered.

## Configuration
- **`PIC_ROTATE_EN` defined:** rotating priority as described above.
- **`PIC_ROTATE_EN` undefined:** the `rotate` input is ignored, `lowest` is tied to 7 and the rotation logic is not built. Priority is always IR0 highest.

## Test plan
- **Edge request and EOI:** fixed mode, `imr`=0x00, `ir_in[3]` 0→1 → `irr`=0x08, then `int_req`=1. `inta1` → `isr`=0x08, `irr`=0x00, `vector_num`=3. `inta2` → `vector_valid` pulses. `eoi` → `isr`=0x00.
- **Nesting:** `isr`=0x04 (IR2 in service). Raise IR5 → `int_req` stays 0. Raise IR1 → `int_req`=1 and the acknowledge latches 1.
- **Masking:** `imr`=0x02, request IR1 → `irr`=0x02 and `int_req`=0. Change `imr` to 0x00 → `int_req`=1 two cycles later.
- **Spurious:** level mode, IR4 high → `int_req`=1. Drop IR4, then `inta1` → `vector_num`=7 and `isr` unchanged.
- **Rotation with AEOI:** `PIC_ROTATE_EN` defined, `rotate`=1, `aeoi`=1. Service IR2 → `lowest`=2 and `isr`=0. Pending IR1 and IR4 → IR4 is serviced first.
- **Reset mid-handshake:** `rst` between `inta1` and `inta2` → all outputs return to reset values in one cycle, and a following `inta2` is ignored.
